// File: rtl/mult_share_arbiter_pkg.sv
// mult_share_arbiter_pkg
//   Shared types and constants for the shared-multiplier block and the
//   quadrature mixer path.
//   - DSZ_DEF    : default signed data word size (Q1.(DSZ-1))
//   - IDW_MAX    : requester id width that covers up to 16 requesters
//   - RND_OFS    : half-LSB rounding offset added to the kept product slice
//   - stage_tag_t: valid bit + requester id carried alongside each pipe stage
//   - rnd_sat    : Q(DSZ-1) product -> rounded, saturated DSZ-bit word
package mult_share_arbiter_pkg;

  localparam int DSZ_DEF = 16;
  localparam int IDW_MAX = 4;
  localparam int RND_OFS = 1;

  typedef struct packed {
    logic               vld;
    logic [IDW_MAX-1:0] id;
  } stage_tag_t;

  // Keeps product bits [2D-1:D-2], adds the half-LSB offset, drops the guard
  // bit and clamps. Only (-1)*(-1) can leave the representable range.
  function automatic logic [DSZ_DEF-1:0] rnd_sat(input logic [2*DSZ_DEF-1:0] prod);
    logic [DSZ_DEF+1:0] r;
    logic [DSZ_DEF:0]   t;
    logic [DSZ_DEF-1:0] res;
    r = (DSZ_DEF+2)'(prod >> (DSZ_DEF-2)) + (DSZ_DEF+2)'(RND_OFS);
    t = (DSZ_DEF+1)'(r >> 1);
    case (t[DSZ_DEF -: 2])
      2'b01:   res = {1'b0, {(DSZ_DEF-1){1'b1}}};
      2'b10:   res = {1'b1, {(DSZ_DEF-1){1'b0}}};
      default: res = t[DSZ_DEF-1:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if
//   Requester-side bundle of the shared multiplier.
//   en        : grant enable
//   req_valid : per-requester operand valid      req_ready : one-hot issue grant
//   req_a/b   : packed operands, k at [k*DSZ +: DSZ]
//   rsp_valid : one-hot result pulse              rsp_data  : shared result bus
//   busy      : any pipeline stage holds an op
//   master = requesters, slave = the arbiter/multiplier.
interface mult_share_arbiter_if #(
  parameter int DSZ  = 16,
  parameter int NREQ = 4
) ();
  logic                en;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*DSZ-1:0] req_a;
  logic [NREQ*DSZ-1:0] req_b;
  logic [NREQ-1:0]     rsp_valid;
  logic [DSZ-1:0]      rsp_data;
  logic                busy;

  modport master (
    output en, req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  en, req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// rr_arbiter
//   Round-robin one-hot grant. Search starts one past the last granted
//   requester and wraps; the pointer only moves on a grant.
//   clk, reset : clock, async active-high reset (pointer -> NREQ-1)
//   req        : request vector          en      : grant enable
//   grant      : one-hot grant (comb)    gnt_any : some requester granted
//   gnt_id     : index of granted requester
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic            gnt_any,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW-1:0] ptr_r;

  // Priority search from ptr+1 around the ring; first hit wins.
  always_comb begin
    int  idx;
    logic hit;
    idx     = 0;
    hit     = 1'b0;
    grant   = '0;
    gnt_any = 1'b0;
    gnt_id  = ptr_r;
    for (int i = 1; i <= NREQ; i++) begin
      idx        = (int'(ptr_r) + i) % NREQ;
      hit        = en & ~reset & ~gnt_any & req[idx];
      grant[idx] = grant[idx] | hit;
      gnt_id     = hit ? IDW'(idx) : gnt_id;
      gnt_any    = gnt_any | hit;
    end
  end

  // Last-grant pointer; reset value makes requester 0 first in line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= IDW'(NREQ-1);
    end else if (gnt_any) begin
      ptr_r <= gnt_id;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/mult_share_arbiter_saturator.sv
// saturator
//   Clamps a signed ISZ-bit value into the signed OSZ-bit range.
//   din  : signed input (ISZ bits)
//   dout : clamped output (OSZ bits)
module saturator #(
  parameter int ISZ = 17,
  parameter int OSZ = 16
) (
  input  logic signed [ISZ-1:0] din,
  output logic        [OSZ-1:0] dout
);

  localparam logic signed [ISZ-1:0] MAX_V = ISZ'((2**(OSZ-1)) - 1);
  localparam logic signed [ISZ-1:0] MIN_V = ISZ'(-(2**(OSZ-1)));

  // Clamp against the output range limits.
  always_comb begin
    if (din > MAX_V) begin
      dout = MAX_V[OSZ-1:0];
    end else if (din < MIN_V) begin
      dout = MIN_V[OSZ-1:0];
    end else begin
      dout = din[OSZ-1:0];
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   One pipelined signed Q1.(DSZ-1) multiplier (round half-up + saturate)
//   shared round-robin between NREQ requesters, one issue per cycle,
//   fixed 3-cycle latency, result returned with a one-hot rsp_valid pulse.
//   clk   : clock
//   reset : async active-high reset, clears all state
//   bus   : requester bundle (slave side), see mult_share_arbiter_if
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int DSZ  = DSZ_DEF,
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_share_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int PSZ = 2 * DSZ;

  logic [NREQ-1:0]       grant_s;
  logic                  gnt_any_s;
  logic [IDW-1:0]        gnt_id_s;
  logic [DSZ-1:0]        a_sel_s;
  logic [DSZ-1:0]        b_sel_s;
  stage_tag_t            s1_r;
  stage_tag_t            s2_r;
  logic signed [DSZ-1:0] a1_r;
  logic signed [DSZ-1:0] b1_r;
  logic signed [PSZ-1:0] prod2_r;
  logic [DSZ+1:0]        rnd_s;
  logic signed [DSZ:0]   sat_in_s;
  logic [DSZ-1:0]        sat_out_s;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req_valid),
    .en      (bus.en),
    .grant   (grant_s),
    .gnt_any (gnt_any_s),
    .gnt_id  (gnt_id_s)
  );

  assign bus.req_ready = grant_s;

  // Operand mux for the granted requester.
  always_comb begin
    a_sel_s = bus.req_a[int'(gnt_id_s)*DSZ +: DSZ];
    b_sel_s = bus.req_b[int'(gnt_id_s)*DSZ +: DSZ];
  end

  // Keep product bits [2D-1:D-2], add half an output LSB, drop the guard bit.
  always_comb begin
    rnd_s    = (DSZ+2)'(prod2_r >> (DSZ-2)) + (DSZ+2)'(RND_OFS);
    sat_in_s = (DSZ+1)'(rnd_s >> 1);
  end

  saturator #(.ISZ(DSZ+1), .OSZ(DSZ)) u_sat (
    .din  (sat_in_s),
    .dout (sat_out_s)
  );

  // S1: capture granted operands and requester id.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r <= '0;
      a1_r <= '0;
      b1_r <= '0;
    end else begin
      s1_r <= '{vld: gnt_any_s, id: IDW_MAX'(gnt_id_s)};
      a1_r <= gnt_any_s ? $signed(a_sel_s) : a1_r;
      b1_r <= gnt_any_s ? $signed(b_sel_s) : b1_r;
    end
  end

  // S2: full-width signed product, registered at the multiplier output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_r    <= '0;
      prod2_r <= '0;
    end else begin
      s2_r    <= s1_r;
      prod2_r <= s1_r.vld ? (PSZ'(a1_r) * PSZ'(b1_r)) : prod2_r;
    end
  end

  // S3: registered result, one-hot response pulse and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.rsp_valid <= s2_r.vld ? (NREQ'(1) << s2_r.id) : '0;
      bus.rsp_data  <= s2_r.vld ? sat_out_s : bus.rsp_data;
      bus.busy      <= gnt_any_s | s1_r.vld | s2_r.vld;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//   Directed, table-driven bench for mult_share_arbiter (DSZ=16, NREQ=4).
//   Expected responses are derived from a 3-deep history of the expected
//   grants, so latency, ordering and busy are all checked every cycle.
module tb_mult_share_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [3:0]  h_rdy [3];
  logic [15:0] h_dat [3];

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [10];

  mult_share_arbiter_if #(.DSZ(16), .NREQ(4)) bus ();

  mult_share_arbiter #(.DSZ(16), .NREQ(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr_hist();
    for (int i = 0; i < 3; i++) begin
      h_rdy[i] = 4'b0;
      h_dat[i] = 16'h0;
    end
  endtask

  // One cycle: drive valid/en, check at negedge, advance to posedge+1.
  task automatic cyc(input logic [3:0] v, input logic e, input logic [3:0] er, input logic [15:0] ed);
    bus.req_valid = v;
    bus.en        = e;
    @(negedge clk);
    chk("req_ready", bus.req_ready, er);
    chk("rsp_valid", bus.rsp_valid, h_rdy[2]);
    if (h_rdy[2] != 4'b0) chk("rsp_data", bus.rsp_data, h_dat[2]);
    chk("busy", bus.busy, (h_rdy[0] | h_rdy[1] | h_rdy[2]) != 4'b0);
    h_rdy[2] = h_rdy[1]; h_dat[2] = h_dat[1];
    h_rdy[1] = h_rdy[0]; h_dat[1] = h_dat[0];
    h_rdy[0] = er;       h_dat[0] = ed;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = 4'hF;
    bus.en        = 1'b1;
    reset         = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", bus.req_ready, 4'b0);
      chk("rst_rsp_valid", bus.rsp_valid, 4'b0);
      chk("rst_rsp_data", bus.rsp_data, 16'h0);
      chk("rst_busy", bus.busy, 1'b0);
      @(posedge clk);
      #1;
    end
    reset         = 1'b0;
    bus.req_valid = 4'b0;
    clr_hist();
  endtask

  // a=0.5 for everyone, b_k=(k+1)/8 -> result (k+1)*0x0800.
  task automatic set_ops();
    for (int k = 0; k < 4; k++) begin
      bus.req_a[k*16 +: 16] = 16'h4000;
      bus.req_b[k*16 +: 16] = 16'(16'h1000 * (k + 1));
    end
  endtask

  initial begin
    clk           = 1'b0;
    reset         = 1'b1;
    total         = 0;
    bad           = 0;
    bus.en        = 1'b0;
    bus.req_valid = 4'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    clr_hist();

    vt[0] = '{0, 16'h4000, 16'h4000, 16'h2000};
    vt[1] = '{1, 16'h8000, 16'h8000, 16'h7FFF};
    vt[2] = '{2, 16'h7FFF, 16'h7FFF, 16'h7FFE};
    vt[3] = '{3, 16'h8000, 16'h4000, 16'hC000};
    vt[4] = '{0, 16'h4000, 16'hC000, 16'hE000};
    vt[5] = '{1, 16'h0001, 16'h4000, 16'h0001};
    vt[6] = '{2, 16'hFFFF, 16'h4000, 16'h0000};
    vt[7] = '{3, 16'h0000, 16'h1234, 16'h0000};
    vt[8] = '{0, 16'hFFFF, 16'h0001, 16'h0000};
    vt[9] = '{1, 16'h8000, 16'h7FFF, 16'h8001};

    do_reset();

    // Arithmetic vectors, one lone requester per cycle, issued back to back.
    for (int i = 0; i < 10; i++) begin
      bus.req_a[vt[i].id*16 +: 16] = vt[i].a;
      bus.req_b[vt[i].id*16 +: 16] = vt[i].b;
      cyc(4'b0001 << vt[i].id, 1'b1, 4'b0001 << vt[i].id, vt[i].exp);
    end
    for (int i = 0; i < 4; i++) cyc(4'b0, 1'b1, 4'b0, 16'h0);
    chk("rsp_data_hold", bus.rsp_data, vt[9].exp);

    // All four valid for 8 cycles: grants 0,1,2,3,0,1,2,3.
    do_reset();
    set_ops();
    for (int i = 0; i < 8; i++) begin
      cyc(4'hF, 1'b1, 4'b0001 << (i % 4), 16'(16'h0800 * (i % 4 + 1)));
    end
    for (int i = 0; i < 4; i++) cyc(4'b0, 1'b1, 4'b0, 16'h0);

    // Requester 2 alone for 5 cycles, then 1+3 with ptr=2 -> 3 then 1.
    for (int i = 0; i < 5; i++) begin
      bus.req_b[2*16 +: 16] = 16'(16'h0200 * (i + 1));
      cyc(4'b0100, 1'b1, 4'b0100, 16'(16'h0100 * (i + 1)));
    end
    set_ops();
    cyc(4'b1010, 1'b1, 4'b1000, 16'h2000);
    cyc(4'b1010, 1'b1, 4'b0010, 16'h1000);
    for (int i = 0; i < 4; i++) cyc(4'b0, 1'b1, 4'b0, 16'h0);

    // en=0 with all valid: no grants, in-flight ops drain, resume at ptr+1.
    cyc(4'hF, 1'b1, 4'b0100, 16'h1800);
    cyc(4'hF, 1'b1, 4'b1000, 16'h2000);
    for (int i = 0; i < 5; i++) cyc(4'hF, 1'b0, 4'b0, 16'h0);
    cyc(4'hF, 1'b1, 4'b0001, 16'h0800);
    cyc(4'hF, 1'b1, 4'b0010, 16'h1000);
    for (int i = 0; i < 4; i++) cyc(4'b0, 1'b1, 4'b0, 16'h0);

    // Reset with three ops in flight: they vanish, requester 0 wins next.
    do_reset();
    cyc(4'hF, 1'b1, 4'b0001, 16'h0800);
    cyc(4'hF, 1'b1, 4'b0010, 16'h1000);
    cyc(4'hF, 1'b1, 4'b0100, 16'h1800);
    do_reset();
    cyc(4'hF, 1'b1, 4'b0001, 16'h0800);
    for (int i = 0; i < 4; i++) cyc(4'b0, 1'b1, 4'b0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
